// File: rtl/logic_axi4_stream_downsizer.sv
// AXI4-Stream width downsizer: one wide Rx beat is replayed as RATIO narrow Tx slices, LSB slice first.
// Optional null-slice skipping is enabled by defining LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN.
module logic_axi4_stream_downsizer #(
  parameter int RX_TDATA_BYTES = 8,
  parameter int TX_TDATA_BYTES = 4,
  parameter int TX_TUSER_WIDTH = 1,
  parameter int RX_TUSER_WIDTH = (RX_TDATA_BYTES / TX_TDATA_BYTES) * TX_TUSER_WIDTH,
  parameter int TDEST_WIDTH    = 1,
  parameter int TID_WIDTH      = 1,
  parameter int USE_TLAST      = 1,
  parameter int USE_TKEEP      = 1,
  parameter int USE_TSTRB      = 1
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        rx_tvalid,
  input  logic                        rx_tlast,
  input  logic [RX_TDATA_BYTES*8-1:0] rx_tdata,
  input  logic [RX_TDATA_BYTES-1:0]   rx_tstrb,
  input  logic [RX_TDATA_BYTES-1:0]   rx_tkeep,
  input  logic [RX_TUSER_WIDTH-1:0]   rx_tuser,
  input  logic [TDEST_WIDTH-1:0]      rx_tdest,
  input  logic [TID_WIDTH-1:0]        rx_tid,
  output logic                        rx_tready,
  output logic                        tx_tvalid,
  output logic                        tx_tlast,
  output logic [TX_TDATA_BYTES*8-1:0] tx_tdata,
  output logic [TX_TDATA_BYTES-1:0]   tx_tstrb,
  output logic [TX_TDATA_BYTES-1:0]   tx_tkeep,
  output logic [TX_TUSER_WIDTH-1:0]   tx_tuser,
  output logic [TDEST_WIDTH-1:0]      tx_tdest,
  output logic [TID_WIDTH-1:0]        tx_tid,
  input  logic                        tx_tready,
  output logic                        dbg_state
);

  localparam int RATIO = RX_TDATA_BYTES / TX_TDATA_BYTES;
  localparam int IDX_W = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int TXD   = TX_TDATA_BYTES * 8;

  if ((RX_TDATA_BYTES % TX_TDATA_BYTES) != 0 || RATIO < 2 ||
      RX_TUSER_WIDTH != RATIO * TX_TUSER_WIDTH) begin : g_bad_cfg
    $error("logic_axi4_stream_downsizer: illegal width configuration");
  end

  // Handshake rule on both ports: a beat moves on a rising aclk edge where valid and ready are both 1;
  // a source holds valid and all payload fields stable until that edge.
  typedef enum logic {ST_EMPTY = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            idx_q, idx_d, nxt_idx, first_idx;
  logic [RX_TDATA_BYTES*8-1:0] data_q, data_d;
  logic [RX_TDATA_BYTES-1:0]   strb_q, strb_d, keep_q, keep_d;
  logic [RX_TUSER_WIDTH-1:0]   user_q, user_d;
  logic [TDEST_WIDTH-1:0]      dest_q, dest_d;
  logic [TID_WIDTH-1:0]        id_q, id_d;
  logic                        last_q, last_d;

  logic [RX_TDATA_BYTES-1:0]   rx_keep_eff, rx_strb_eff;
  logic                        rx_tlast_eff;
  logic                        is_final, rx_keep_beat, rx_hs, tx_hs;

  assign rx_keep_eff  = (USE_TKEEP != 0) ? rx_tkeep : '1;
  assign rx_strb_eff  = (USE_TSTRB != 0) ? rx_tstrb : rx_keep_eff;
  assign rx_tlast_eff = (USE_TLAST != 0) ? rx_tlast : 1'b0;

`ifdef LOGIC_AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN
  logic [RATIO-1:0] held_nz, rx_nz;
  logic             nxt_found;

  // Final slice is the last one with any kept byte; an all-null beat with tlast shows as the top slice.
  always_comb begin
    held_nz = '0;
    rx_nz   = '0;
    for (int r = 0; r < RATIO; r++) begin
      held_nz[r] = |keep_q[r*TX_TDATA_BYTES +: TX_TDATA_BYTES];
      rx_nz[r]   = |rx_keep_eff[r*TX_TDATA_BYTES +: TX_TDATA_BYTES];
    end
    nxt_found = 1'b0;
    nxt_idx   = idx_q;
    first_idx = IDX_W'(RATIO - 1);
    for (int r = RATIO - 1; r >= 0; r--) begin
      if (held_nz[r] && (r > int'(idx_q))) begin
        nxt_found = 1'b1;
        nxt_idx   = IDX_W'(r);
      end
      if (rx_nz[r]) first_idx = IDX_W'(r);
    end
    is_final     = !nxt_found;
    rx_keep_beat = (|rx_nz) || rx_tlast_eff;
  end
`else
  always_comb begin
    nxt_idx      = idx_q + IDX_W'(1);
    first_idx    = '0;
    is_final     = (idx_q == IDX_W'(RATIO - 1));
    rx_keep_beat = 1'b1;
  end
`endif

  assign tx_tvalid = (state_q == ST_SHIFT);
  assign tx_hs     = tx_tvalid && tx_tready;
  // Reload is allowed in the same cycle the final slice leaves, so the output never bubbles.
  assign rx_tready = !areset && ((state_q == ST_EMPTY) || (tx_tvalid && is_final && tx_tready));
  assign rx_hs     = rx_tvalid && rx_tready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    strb_d  = strb_q;
    keep_d  = keep_q;
    user_d  = user_q;
    dest_d  = dest_q;
    id_d    = id_q;
    last_d  = last_q;
    if (tx_hs) begin
      if (is_final) state_d = ST_EMPTY;
      else          idx_d   = nxt_idx;
    end
    if (rx_hs) begin
      data_d  = rx_tdata;
      strb_d  = rx_strb_eff;
      keep_d  = rx_keep_eff;
      user_d  = rx_tuser;
      dest_d  = rx_tdest;
      id_d    = rx_tid;
      last_d  = rx_tlast_eff;
      idx_d   = first_idx;
      state_d = rx_keep_beat ? ST_SHIFT : ST_EMPTY;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      keep_q  <= '0;
      user_q  <= '0;
      dest_q  <= '0;
      id_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      keep_q  <= keep_d;
      user_q  <= user_d;
      dest_q  <= dest_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign tx_tdata  = data_q[int'(idx_q)*TXD +: TXD];
  assign tx_tkeep  = (USE_TKEEP != 0) ? keep_q[int'(idx_q)*TX_TDATA_BYTES +: TX_TDATA_BYTES] : '1;
  assign tx_tstrb  = (USE_TSTRB != 0) ? strb_q[int'(idx_q)*TX_TDATA_BYTES +: TX_TDATA_BYTES] : tx_tkeep;
  assign tx_tuser  = user_q[int'(idx_q)*TX_TUSER_WIDTH +: TX_TUSER_WIDTH];
  assign tx_tdest  = dest_q;
  assign tx_tid    = id_q;
  assign tx_tlast  = (USE_TLAST != 0) && tx_tvalid && last_q && is_final;
  assign dbg_state = state_q;

endmodule
